// File: rtl/button_debounce_pkg.sv
// Shared FSM state encoding and default cycle counts for the button debouncer.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    StLow     = 2'd0,
    StChkHigh = 2'd1,
    StHigh    = 2'd2,
    StChkLow  = 2'd3
  } state_e;

  // 10 ms debounce and 1 s hold at 25 MHz
  localparam int DebounceCyclesDefault = 250000;
  localparam int HoldCyclesDefault     = 25000000;

endpackage

// File: rtl/debounce_channel.sv
// One debounced button channel: stability-counter FSM plus registered level/press/release
// outputs, and an optional hold-pulse counter (BUTTON_DEBOUNCE_HOLD_EN).
module debounce_channel
  import button_debounce_pkg::*;
#(
  parameter int DebounceCycles = DebounceCyclesDefault,
  parameter int HoldCycles     = HoldCyclesDefault
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic button_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o
);

  localparam int CntW = $clog2(DebounceCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StLow;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      StLow: begin
        if (button_i) begin
          state_d = StChkHigh;
          cnt_d   = '0;
        end
      end
      StChkHigh: begin
        if (!button_i) begin
          state_d = StLow;
        end else if (cnt_q == CntMax) begin
          state_d = StHigh;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHigh: begin
        if (!button_i) begin
          state_d = StChkLow;
          cnt_d   = '0;
        end
      end
      StChkLow: begin
        if (button_i) begin
          state_d = StHigh;
        end else if (cnt_q == CntMax) begin
          state_d   = StLow;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StLow;
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BUTTON_DEBOUNCE_HOLD_EN
  localparam int HoldW = $clog2(HoldCycles + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HoldCycles);

  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             hold_q, hold_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_cnt_q <= '0;
      hold_q     <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      hold_q     <= hold_d;
    end
  end

  // Cleared only on a fresh press so a bounce back into StHigh cannot re-arm the pulse
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    hold_d     = 1'b0;
    if (state_q == StChkHigh && state_d == StHigh) begin
      hold_cnt_d = '0;
    end else if ((state_q == StHigh || state_q == StChkLow) && state_d != StLow &&
                 hold_cnt_q != HoldMax) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
      hold_d     = (hold_cnt_q == HoldMax - 1'b1);
    end
  end

  assign hold_o = hold_q;
`else
  assign hold_o = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// Width independent button debouncers; hold pulses exist only when
// BUTTON_DEBOUNCE_HOLD_EN is defined, otherwise hold_o is constant 0.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int Width          = 3,
  parameter int DebounceCycles = DebounceCyclesDefault,
  parameter int HoldCycles     = HoldCyclesDefault
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] button_i,
  output logic [Width-1:0] level_o,
  output logic [Width-1:0] press_o,
  output logic [Width-1:0] release_o,
  output logic [Width-1:0] hold_o
);

  for (genvar gi = 0; gi < Width; gi++) begin : g_ch
    debounce_channel #(
      .DebounceCycles(DebounceCycles),
      .HoldCycles    (HoldCycles)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .button_i (button_i[gi]),
      .level_o  (level_o[gi]),
      .press_o  (press_o[gi]),
      .release_o(release_o[gi]),
      .hold_o   (hold_o[gi])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: run-length reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_button_debounce;

  localparam int W = 3;
  localparam int D = 4;
  localparam int H = 10;
`ifdef BUTTON_DEBOUNCE_HOLD_EN
  localparam bit HoldEn = 1'b1;
`else
  localparam bit HoldEn = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic [W-1:0] button_i = 3'b111;
  logic [W-1:0] level_o, press_o, release_o, hold_o;

  always #20 clk_i = ~clk_i;

  button_debounce #(
    .Width(W), .DebounceCycles(D), .HoldCycles(H)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .button_i(button_i),
    .level_o(level_o), .press_o(press_o), .release_o(release_o), .hold_o(hold_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Model: a change is accepted once D+1 consecutive samples differ from the stable value
  bit           m_stable[W];
  int           m_run[W];
  int           m_age[W];
  logic [W-1:0] exp_level = '0, exp_press = '0, exp_rel = '0, exp_hold = '0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < W; i++) begin
        m_stable[i] = 1'b0;
        m_run[i]    = 0;
        m_age[i]    = 0;
      end
      exp_level = '0; exp_press = '0; exp_rel = '0; exp_hold = '0;
    end else begin
      exp_press = '0; exp_rel = '0; exp_hold = '0;
      for (int i = 0; i < W; i++) begin
        bit was_high;
        was_high = m_stable[i];
        if (button_i[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == D + 1) begin
            m_stable[i] = button_i[i];
            m_run[i]    = 0;
            if (button_i[i]) begin
              exp_press[i] = 1'b1;
              m_age[i]     = 0;
            end else begin
              exp_rel[i] = 1'b1;
            end
          end
        end else begin
          m_run[i] = 0;
        end
        if (was_high && m_stable[i]) begin
          m_age[i]++;
          if (m_age[i] == H && HoldEn) exp_hold[i] = 1'b1;
        end
        exp_level[i] = m_stable[i];
      end
    end
  end

  always @(negedge clk_i) begin
    #2;
    chk("model_level", level_o, exp_level);
    chk("model_press", press_o, exp_press);
    chk("model_release", release_o, exp_rel);
    chk("model_hold", hold_o, exp_hold);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
    #3;
  endtask

  initial begin
    // Reset held with all buttons pressed
    step(3);
    chk("rst_level", level_o, 3'b000);
    chk("rst_press", press_o, 3'b000);
    chk("rst_release", release_o, 3'b000);
    chk("rst_hold", hold_o, 3'b000);
    rst_ni = 1'b1;
    step(4);
    chk("rstrel_e3_level", level_o, 3'b000);
    step(1);
    chk("rstrel_e4_level", level_o, 3'b111);
    chk("rstrel_e4_press", press_o, 3'b111);
    step(1);
    chk("rstrel_e5_press", press_o, 3'b000);
    button_i = 3'b000;
    step(5);
    chk("all_release", release_o, 3'b111);
    chk("all_release_level", level_o, 3'b000);
    step(1);

    // Clean press on bit0, 12 cycles high
    button_i = 3'b001;
    step(4);
    chk("clean_e3_press", press_o, 3'b000);
    step(1);
    chk("clean_press", press_o, 3'b001);
    chk("clean_level", level_o, 3'b001);
    step(7);
    button_i = 3'b000;
    step(4);
    chk("clean_rel_e3", release_o, 3'b000);
    step(1);
    chk("clean_release", release_o, 3'b001);
    chk("clean_rel_level", level_o, 3'b000);
    step(2);

    // Glitch on bit1: 3 samples high
    button_i = 3'b010;
    step(3);
    button_i = 3'b000;
    step(5);
    chk("glitch_level", level_o, 3'b000);
    chk("glitch_press", press_o, 3'b000);

    // Bounce on bit2: 1,0,1,1,0,1 then steady 1
    begin
      logic [5:0] pat;
      pat = 6'b101101;
      for (int k = 5; k >= 0; k--) begin
        button_i = {pat[k], 2'b00};
        step(1);
      end
    end
    step(3);
    chk("bounce_early", press_o, 3'b000);
    step(1);
    chk("bounce_press", press_o, 3'b100);
    chk("bounce_level", level_o, 3'b100);
    step(2);

    // Reset mid-check on bit0 while bit2 is still debounced high
    button_i = 3'b001;
    step(3);
    rst_ni = 1'b0;
    #1;
    chk("midrst_level", level_o, 3'b000);
    chk("midrst_press", press_o, 3'b000);
    step(1);
    rst_ni = 1'b1;
    step(4);
    chk("midrst_e3_level", level_o, 3'b000);
    step(1);
    chk("midrst_press_after", press_o, 3'b001);
    chk("midrst_level_after", level_o, 3'b001);

    // Hold on bit0: pulse 10 edges after press
    step(9);
    chk("hold_early", hold_o, 3'b000);
    step(1);
    chk("hold_pulse", hold_o, HoldEn ? 3'b001 : 3'b000);
    step(1);
    chk("hold_after", hold_o, 3'b000);
    step(10);
    button_i = 3'b000;
    step(6);
    chk("hold_end_level", level_o, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Debounces the three already-synchronized push-button lines on the 25 MHz PLL clock domain before they reach the UART/AXI-stream control logic. Each channel runs an independent stability-counter FSM and produces three outputs: a debounced level, a one-cycle press pulse and a one-cycle release pulse. It sits between the two-flop button synchronizers and the `button_i` input of the UART stream core.

## Interface
- `Width`, 3: number of independent button channels.
- `DebounceCycles`, 250000: consecutive cycles an input must differ from the stable value before the change is accepted (10 ms at 25 MHz); legal range ≥ 2.
- `HoldCycles`, 25000000: cycles in the pressed state before `hold_o` fires (1 s); used only with `BUTTON_DEBOUNCE_HOLD_EN`; must be ≥ 1.
- `clk_i`  in  1  25 MHz system clock.
- `rst_ni`  in  1  reset, asynchronous assert, active-low.
- `button_i`  in  Width  synchronized raw button levels, 1 = pressed.
- `level_o`  out  Width  debounced level per channel.
- `press_o`  out  Width  one-cycle pulse on an accepted 0→1 transition.
- `release_o`  out  Width  one-cycle pulse on an accepted 1→0 transition.
- `hold_o`  out  Width  one-cycle pulse once per press after `HoldCycles`.

## Operation
- Per-channel FSM with four states: `StLow`, `StChkHigh`, `StHigh`, `StChkLow`. Reset state is `StLow`.
- Counter width is `$clog2(DebounceCycles)`. The counter is cleared on entry to either check state.
- `StLow`: if `button_i`=1, go to `StChkHigh` with cnt=0.
- `StChkHigh`:
  - `button_i`=0: return to `StLow` with no output.
  - `button_i`=1 and cnt≠DebounceCycles-1: cnt++.
  - `button_i`=1 and cnt==DebounceCycles-1: go to `StHigh`, set `level_o`=1, pulse `press_o`.
- `StHigh` and `StChkLow` mirror the above with polarity inverted. Acceptance pulses `release_o` and clears `level_o`.
- Any bounce back to the stable value restarts qualification from cnt=0 on the next departure. No partial credit is kept.
- Channels are fully independent. Simultaneous events on different channels are handled in the same cycle.
- All outputs are registered. `press_o`, `release_o` and `hold_o` are high for exactly one cycle per event.
- Reset assertion at any time, including mid-check, aborts immediately: state `StLow`, all counters 0.
- A button held through reset release is treated as a fresh press. It is debounced and produces one `press_o`.

## Timing
- Reset values: `level_o`=0, `press_o`=0, `release_o`=0, `hold_o`=0. The reset is asynchronous; outputs clear without a clock.
- Latency: let E0 be the first edge sampling the new value. If the value is held, the output changes after edge E_DebounceCycles, i.e. DebounceCycles+1 consecutive sampling edges in total.
- `press_o` and `level_o` rise on the same edge. `release_o` and the falling `level_o` also coincide.
- Minimum spacing between `press_o` and the following `release_o` on one channel is DebounceCycles+1 cycles.
- There is no handshake. The consumer must sample the pulses every cycle.

## Configuration
- `BUTTON_DEBOUNCE_HOLD_EN` defined:
  - Each channel has a hold counter of width `$clog2(HoldCycles+1)`, cleared on entry to `StHigh`.
  - The counter increments while in `StHigh` or `StChkLow` and saturates at `HoldCycles`.
  - `hold_o` pulses on the edge the counter reaches `HoldCycles`. It pulses at most once per press.
  - A release cancels the hold without a pulse.
- `BUTTON_DEBOUNCE_HOLD_EN` undefined: `hold_o` is tied to 0 and no hold counter is synthesized.

## Structure
- `button_debounce_pkg`: `state_e` enum (`StLow`, `StChkHigh`, `StHigh`, `StChkLow`) and the default cycle-count constants `DebounceCyclesDefault` and `HoldCyclesDefault`.
- Sub-module `debounce_channel`: one channel containing the FSM, counters and output registers. `button_debounce` instantiates Width copies in a generate loop.

## Test plan
Bench parameters: DebounceCycles=4, HoldCycles=10.
- Reset: hold `rst_ni`=0 with `button_i`=3'b111 → all outputs 0. Release reset → `level_o`=3'b111 and `press_o`=3'b111 for one cycle, after edge E4.
- Clean press on bit0 held 12 cycles, then released → `press_o[0]` pulses once after E4; `release_o[0]` pulses once 4 edges after the first 0 sample.
- Glitch: bit1 high for 3 cycles, then low → `level_o[1]` stays 0 and no pulses occur.
- Bounce: bit2 pattern 1,0,1,1,0,1 then steady 1 → exactly one `press_o[2]`, after the 5th consecutive 1 counted from the last rising sample.
- Reset mid-check: bit0 high for 3 cycles, then `rst_ni`=0 for 1 cycle with input still high → outputs 0 immediately. After reset, the press is reported after a full 4-cycle requalification.
- Hold, with the macro defined: bit0 held 20 cycles past `press_o` → `hold_o[0]` pulses once, 10 cycles after `press_o[0]`. Without the macro, `hold_o` stays 3'b000.
